m_bus_timer: RTL

- 6502 memory-mapped interval timer with a programmable prescaler, in the style of the RIOT timer.
- Sits on the CPU bus after the address-decode primitives.
- Generates an active-low IRQ and timer/status read data for the CPU data-in mux.
- Count steps once per 6502 bus cycle, qualified by the `phi2_en` strobe, never per `clk`.

---
 rtl/bus_timer_pkg.sv | 27 ++
 rtl/m_offset_check.sv | 16 +
 rtl/m_prescaler.sv | 32 +++
 rtl/m_bus_timer.sv | 118 +++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared types and helpers for the 6502 RIOT-style interval timer.
// Prescaler reload values are the interval minus one, so pcnt counts down to zero.
package bus_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPIRED
  } timer_state_t;

  typedef logic [1:0] presc_sel_t;

  localparam int OFF_STATUS_BIT = 0;
  localparam int OFF_IRQEN_BIT  = 2;

  function automatic logic [9:0] presc_reload(presc_sel_t sel);
    logic [9:0] val;
    case (sel)
      2'd0:    val = 10'd0;
      2'd1:    val = 10'd7;
      2'd2:    val = 10'd63;
      default: val = 10'd1023;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/m_offset_check.sv
// Address window decode primitive: in_range when low <= value <= low + delta.
module m_offset_check #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] low   = '0,
  parameter logic [WIDTH-1:0] delta = '0
) (
  input  logic [WIDTH-1:0] value,
  output logic             in_range
);

  logic [WIDTH-1:0] diff;

  assign diff     = value - low;
  assign in_range = (value >= low) && (diff <= delta);

endmodule

// File: rtl/m_prescaler.sv
// Down-counting prescaler; terminal pulses on a tick that finds pcnt at zero.
// A reload overrides any tick in the same cycle.
module m_prescaler (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       reload,
  input  logic [9:0] reload_val,
  output logic       terminal
);

  logic [9:0] pcnt_reg;
  logic [9:0] pcnt_next;

  assign terminal = tick && !reload && (pcnt_reg == 10'd0);

  always_comb begin
    pcnt_next = pcnt_reg;
    if (reload) begin
      pcnt_next = reload_val;
    end else if (tick) begin
      if (pcnt_reg == 10'd0) pcnt_next = reload_val;
      else                   pcnt_next = pcnt_reg - 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) pcnt_reg <= 10'd0;
    else     pcnt_reg <= pcnt_next;
  end

endmodule

// File: rtl/m_bus_timer.sv
// 6502 memory-mapped interval timer with prescaler and active-low IRQ.
// All bus side effects and counting are qualified by the phi2_en bus-cycle strobe.
module m_bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [15:0] BASE   = 16'h1800,
  parameter int          ADDR_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              phi2_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              hit,
  output logic              irq_n
);

  timer_state_t state_reg, state_next;
  logic [7:0]   count_reg, count_next;
  presc_sel_t   sel_reg, sel_next;
  logic         irq_en_reg, irq_en_next;
  logic         flag_reg, flag_next;
  logic         irq_n_reg;

  logic [2:0]   off;
  logic         wr;
  logic         rd;
  logic         presc_tick;
  logic         terminal;
  logic [9:0]   reload_val;

  m_offset_check #(
    .WIDTH (ADDR_W),
    .low   (ADDR_W'(BASE)),
    .delta (ADDR_W'(7))
  ) u_decode (
    .value    (addr),
    .in_range (hit)
  );

  assign off        = addr[2:0];
  assign wr         = phi2_en && hit && we;
  assign rd         = phi2_en && hit && !we;
  assign presc_tick = phi2_en && !wr && (state_reg == COUNT);
  // A write reloads with its own new select; otherwise the wrap uses the held one.
  assign reload_val = wr ? presc_reload(presc_sel_t'(off[1:0])) : presc_reload(sel_reg);

  m_prescaler u_presc (
    .clk        (clk),
    .clr        (clr),
    .tick       (presc_tick),
    .reload     (wr),
    .reload_val (reload_val),
    .terminal   (terminal)
  );

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    sel_next    = sel_reg;
    irq_en_next = irq_en_reg;
    flag_next   = flag_reg;
    if (wr) begin
      count_next  = data_in;
      sel_next    = presc_sel_t'(off[1:0]);
      irq_en_next = off[OFF_IRQEN_BIT];
      flag_next   = 1'b0;
      state_next  = COUNT;
    end else if (phi2_en) begin
      if (rd && !off[OFF_STATUS_BIT]) flag_next = 1'b0;
      // Expiry is evaluated after the clearing read so a simultaneous set wins.
      case (state_reg)
        COUNT: begin
          if (terminal) begin
            count_next = count_reg - 8'd1;
            if (count_reg == 8'h00) begin
              flag_next  = 1'b1;
              state_next = EXPIRED;
            end
          end
        end
        EXPIRED: count_next = count_reg - 8'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg  <= IDLE;
      count_reg  <= 8'h00;
      sel_reg    <= 2'd0;
      irq_en_reg <= 1'b0;
      flag_reg   <= 1'b0;
      irq_n_reg  <= 1'b1;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      sel_reg    <= sel_next;
      irq_en_reg <= irq_en_next;
      flag_reg   <= flag_next;
      irq_n_reg  <= ~(flag_next & irq_en_next);
    end
  end

  assign irq_n = irq_n_reg;

  always_comb begin
    data_out = 8'h00;
    if (hit && !we) begin
      if (!off[OFF_STATUS_BIT]) data_out = count_reg;
      else                      data_out = {flag_reg, irq_en_reg, 6'b0};
    end
  end

endmodule
